// File: rtl/op2_fetch_ctrl.sv
// op2_fetch_ctrl: operand-2 fetch sequencer sharing the byte RAM read port round-robin with one peripheral
module op2_fetch_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [1:0]        fetchSrc,
    input  logic [ADDR_W-1:0] fetchAddr,
    output logic              fetchBusy,
    output logic [7:0]        op2Out,
    output logic              op2Valid,
    output logic [1:0]        op2MuxSel,
    output logic [ADDR_W-1:0] rdAddr,
    output logic              inputRdEn,
    output logic              outputRdEn,
    output logic              bitRdEn,
    output logic              byteRdEn,
    input  logic              inputReadOut,
    input  logic              outputReadOut,
    input  logic              bitOut,
    input  logic [7:0]        byteOut,
    input  logic              periphReq,
    input  logic [ADDR_W-1:0] periphAddr,
    output logic              periphGnt,
    output logic [7:0]        periphData,
    output logic              periphValid
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
    state_t            state_q, state_d;
    logic [1:0]        src_q, src_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              periph_q, periph_d, rr_q, rr_d;
    logic [7:0]        op2_q, op2_d, pdata_q, pdata_d;
    logic              op2_vld_q, op2_vld_d, pvld_q, pvld_d;
    logic              idle, issue, pipe_win, periph_win;
    logic [2:0]        lat;
    logic [7:0]        cap_data;
    // rr_q set means the peripheral owns the tie-break
    assign idle       = state_q == IDLE;
    assign issue      = (state_q == ISSUE) & ~reset;
    assign pipe_win   = fetchReq & (~periphReq | ~rr_q);
    assign periph_win = periphReq & ~pipe_win;
    assign lat        = src_q[1] ? 3'(RAM_LAT) : 3'd1;
    assign cap_data   = src_q == 2'd3 ? byteOut
                      : {7'b0, src_q == 2'd2 ? bitOut : src_q[0] ? outputReadOut : inputReadOut};
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        addr_d    = addr_q;
        periph_d  = periph_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        op2_d     = op2_q;
        pdata_d   = pdata_q;
        op2_vld_d = 1'b0;
        pvld_d    = 1'b0;
        case (state_q)
            IDLE: if (fetchReq | periphReq) begin
                state_d  = ISSUE;
                periph_d = periph_win;
                src_d    = periph_win ? 2'd3 : fetchSrc;
                addr_d   = periph_win ? periphAddr : fetchAddr;
                rr_d     = (fetchReq & periphReq) ? pipe_win : rr_q;
            end
            ISSUE: begin
                state_d = lat == 3'd1 ? CAPTURE : WAIT;
                cnt_d   = 2'(lat - 3'd2);
            end
            WAIT: begin
                state_d = cnt_q == 2'd0 ? CAPTURE : WAIT;
                cnt_d   = cnt_q - 2'd1;
            end
            CAPTURE: begin
                state_d   = IDLE;
                op2_d     = periph_q ? op2_q : cap_data;
                pdata_d   = periph_q ? cap_data : pdata_q;
                op2_vld_d = ~periph_q;
                pvld_d    = periph_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= 2'd0;
            addr_q    <= '0;
            periph_q  <= 1'b0;
            rr_q      <= 1'b0;
            cnt_q     <= 2'd0;
            op2_q     <= 8'd0;
            pdata_q   <= 8'd0;
            op2_vld_q <= 1'b0;
            pvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            addr_q    <= addr_d;
            periph_q  <= periph_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            op2_q     <= op2_d;
            pdata_q   <= pdata_d;
            op2_vld_q <= op2_vld_d;
            pvld_q    <= pvld_d;
        end
    end
    assign fetchBusy   = ~idle | (fetchReq & periph_win);
    assign periphGnt   = idle & periph_win & ~reset;
    assign inputRdEn   = issue & (src_q == 2'd0);
    assign outputRdEn  = issue & (src_q == 2'd1);
    assign bitRdEn     = issue & (src_q == 2'd2);
    assign byteRdEn    = issue & (src_q == 2'd3);
    assign op2MuxSel   = src_q;
    assign rdAddr      = addr_q;
    assign op2Out      = op2_q;
    assign op2Valid    = op2_vld_q;
    assign periphData  = pdata_q;
    assign periphValid = pvld_q;
    lat_range: assert property (@(posedge clk) RAM_LAT >= 1 && RAM_LAT <= 4);
endmodule
